// File: rtl/execute_mem_uncached_ctrl.sv
// rtl/execute_mem_uncached_ctrl.sv - uncached load/store sequencer for the memory-execute stage
//
// Takes an uncached load or store from the stage-1 register and runs it on the
// external bus, which allows one outstanding transaction. Stage 1 is stalled
// while the access is in flight, and the completion is returned to writeback
// with its ROB tag and fetch id.
//
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   bco_valid              branch-commit override flush
//   i_valid .. i_src1_value stage-1 entry (tag, fetch id, size, kind, address, store data)
//   o_stall                holds the stage-1 register
//   o_bus_* / i_bus_*      single-outstanding bus request/acknowledge port
//   o_wb_*                 one-cycle completion to writeback
module execute_mem_uncached_ctrl #(
  parameter int ROB_W = 4,
  parameter int FID_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             bco_valid,
  input  logic             i_valid,
  input  logic [ROB_W-1:0] i_dst_rob,
  input  logic [FID_W-1:0] i_fid,
  input  logic             i_s_byte,
  input  logic             i_s_store,
  input  logic             i_s_load,
  input  logic [31:0]      i_p_addr,
  input  logic             i_p_uncached,
  input  logic [31:0]      i_src1_value,
  output logic             o_stall,
  output logic             o_bus_req,
  output logic             o_bus_we,
  output logic [31:0]      o_bus_addr,
  output logic [31:0]      o_bus_wdata,
  output logic [3:0]       o_bus_strb,
  input  logic             i_bus_ack,
  input  logic [31:0]      i_bus_rdata,
  output logic             o_wb_valid,
  output logic [ROB_W-1:0] o_wb_dst_rob,
  output logic [FID_W-1:0] o_wb_fid,
  output logic [31:0]      o_wb_data
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [ROB_W-1:0] rob_q, rob_d;
  logic [FID_W-1:0] fid_q, fid_d;
  logic             byte_q, byte_d;
  logic             store_q, store_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       strb_q, strb_d;
  logic [31:0]      data_q, data_d;

  logic             accept;
  logic [31:0]      rdata_shifted;
  logic [31:0]      load_result;

  assign accept = (state_q == ST_IDLE) & i_valid & i_p_uncached &
                  (i_s_load | i_s_store) & ~bco_valid;

  // Byte accesses keep the unaligned address, so addr_q[1:0] selects the
  // little-endian lane of the returned word.
  assign rdata_shifted = i_bus_rdata >> {addr_q[1:0], 3'b000};
  assign load_result   = store_q ? 32'h0 :
                         byte_q  ? {24'h0, rdata_shifted[7:0]} : i_bus_rdata;

  always_comb begin
    state_d = state_q;
    rob_d   = rob_q;
    fid_d   = fid_q;
    byte_d  = byte_q;
    store_d = store_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_REQ;
          rob_d   = i_dst_rob;
          fid_d   = i_fid;
          byte_d  = i_s_byte;
          store_d = i_s_store;  // load+store together is a store
          addr_d  = i_s_byte ? i_p_addr : {i_p_addr[31:2], 2'b00};
          strb_d  = i_s_byte ? (4'b0001 << i_p_addr[1:0]) : 4'hF;
          wdata_d = i_s_byte ? {4{i_src1_value[7:0]}} : i_src1_value;
          data_d  = 32'h0;
        end
      end
      ST_REQ: begin
        if (i_bus_ack) begin
          state_d = bco_valid ? ST_IDLE : ST_RESP;
          data_d  = load_result;
        end else if (bco_valid) begin
          // The request is already visible on the bus; finish it silently.
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (i_bus_ack) state_d = ST_IDLE;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      rob_q   <= '0;
      fid_q   <= '0;
      byte_q  <= 1'b0;
      store_q <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      strb_q  <= 4'h0;
      data_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      rob_q   <= rob_d;
      fid_q   <= fid_d;
      byte_q  <= byte_d;
      store_q <= store_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      data_q  <= data_d;
    end
  end

  assign o_bus_req    = (state_q == ST_REQ) | (state_q == ST_DRAIN);
  assign o_stall      = accept | o_bus_req;
  assign o_bus_we     = store_q;
  assign o_bus_addr   = addr_q;
  assign o_bus_wdata  = wdata_q;
  assign o_bus_strb   = strb_q;
  assign o_wb_valid   = (state_q == ST_RESP) & ~bco_valid;
  assign o_wb_dst_rob = rob_q;
  assign o_wb_fid     = fid_q;
  assign o_wb_data    = data_q;

endmodule

// File: tb/tb_execute_mem_uncached_ctrl.sv
// tb/tb_execute_mem_uncached_ctrl.sv - self-checking bench for execute_mem_uncached_ctrl
module tb_execute_mem_uncached_ctrl;

  localparam int ROB_W = 4;
  localparam int FID_W = 8;

  logic             clk;
  logic             resetn;
  logic             bco_valid;
  logic             i_valid;
  logic [ROB_W-1:0] i_dst_rob;
  logic [FID_W-1:0] i_fid;
  logic             i_s_byte;
  logic             i_s_store;
  logic             i_s_load;
  logic [31:0]      i_p_addr;
  logic             i_p_uncached;
  logic [31:0]      i_src1_value;
  logic             o_stall;
  logic             o_bus_req;
  logic             o_bus_we;
  logic [31:0]      o_bus_addr;
  logic [31:0]      o_bus_wdata;
  logic [3:0]       o_bus_strb;
  logic             i_bus_ack;
  logic [31:0]      i_bus_rdata;
  logic             o_wb_valid;
  logic [ROB_W-1:0] o_wb_dst_rob;
  logic [FID_W-1:0] o_wb_fid;
  logic [31:0]      o_wb_data;

  int errors = 0;
  int checks = 0;

  execute_mem_uncached_ctrl #(.ROB_W(ROB_W), .FID_W(FID_W)) dut (
    .clk(clk), .resetn(resetn), .bco_valid(bco_valid), .i_valid(i_valid),
    .i_dst_rob(i_dst_rob), .i_fid(i_fid), .i_s_byte(i_s_byte), .i_s_store(i_s_store),
    .i_s_load(i_s_load), .i_p_addr(i_p_addr), .i_p_uncached(i_p_uncached),
    .i_src1_value(i_src1_value), .o_stall(o_stall), .o_bus_req(o_bus_req),
    .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata),
    .o_bus_strb(o_bus_strb), .i_bus_ack(i_bus_ack), .i_bus_rdata(i_bus_rdata),
    .o_wb_valid(o_wb_valid), .o_wb_dst_rob(o_wb_dst_rob), .o_wb_fid(o_wb_fid),
    .o_wb_data(o_wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: what the bus and writeback should carry for an access.
  function automatic logic [31:0] m_addr(input logic [31:0] a, input logic b);
    return b ? a : a - (a % 32'd4);
  endfunction
  function automatic logic [3:0] m_strb(input logic [31:0] a, input logic b);
    return b ? 4'(32'd1 << (a % 32'd4)) : 4'hF;
  endfunction
  function automatic logic [31:0] m_wdata(input logic [31:0] s, input logic b);
    return b ? (s % 32'd256) * 32'h01010101 : s;
  endfunction
  function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [31:0] a,
                                         input logic b, input logic st);
    if (st) return 32'h0;
    if (b) return (rd / (32'd1 << (32'd8 * (a % 32'd4)))) % 32'd256;
    return rd;
  endfunction

  task automatic idle_inputs();
    bco_valid = 0; i_valid = 0; i_dst_rob = '0; i_fid = '0; i_s_byte = 0;
    i_s_store = 0; i_s_load = 0; i_p_addr = 0; i_p_uncached = 0; i_src1_value = 0;
    i_bus_ack = 0; i_bus_rdata = 0;
  endtask

  // Presents one stage-1 entry, behaves like the pipeline around it (entry
  // held while stalled, dropped after a flush), acks after `ad` request cycles
  // and asserts bco_valid in cycle `bco_at` (-1 = never). Only observes.
  task automatic run_txn(
    input logic [3:0] rob, input logic [7:0] fid, input logic bt, st, ld, unc,
    input logic [31:0] addr, src, rd, input int ad, input int bco_at,
    output int n_stall, output int n_req, output int n_wb, output int wb_at,
    output logic [3:0] w_rob, output logic [7:0] w_fid, output logic [31:0] w_data,
    output logic b_we, output logic [31:0] b_addr, output logic [31:0] b_wdata,
    output logic [3:0] b_strb, output logic stable);
    logic prev_stall, flushed;
    n_stall = 0; n_req = 0; n_wb = 0; wb_at = -1; w_rob = 0; w_fid = 0; w_data = 0;
    b_we = 0; b_addr = 0; b_wdata = 0; b_strb = 0; stable = 1;
    prev_stall = 0; flushed = 0;
    for (int c = 0; c < ad + 7; c++) begin
      @(negedge clk);
      i_valid = !flushed && (c == 0 || prev_stall);
      i_dst_rob = rob; i_fid = fid; i_s_byte = bt; i_s_store = st; i_s_load = ld;
      i_p_addr = addr; i_p_uncached = unc; i_src1_value = src;
      bco_valid = (c == bco_at);
      if (o_bus_req) i_bus_ack = (n_req == ad);
      else i_bus_ack = 1'($urandom_range(0, 1));
      i_bus_rdata = (o_bus_req && i_bus_ack) ? rd : $urandom;
      #1;
      if (o_stall) n_stall++;
      if (o_bus_req) begin
        if (n_req == 0) begin
          b_we = o_bus_we; b_addr = o_bus_addr; b_wdata = o_bus_wdata; b_strb = o_bus_strb;
        end else if ({b_we, b_addr, b_wdata, b_strb} !== {o_bus_we, o_bus_addr, o_bus_wdata, o_bus_strb}) begin
          stable = 0;
        end
        n_req++;
      end
      if (o_wb_valid) begin
        n_wb++; wb_at = c; w_rob = o_wb_dst_rob; w_fid = o_wb_fid; w_data = o_wb_data;
      end
      prev_stall = o_stall;
      if (bco_valid) flushed = 1;
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({o_bus_req, o_wb_valid, o_stall, o_bus_we} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 0000", {o_bus_req, o_wb_valid, o_stall, o_bus_we});
    end
    checks++;
    if ({o_bus_addr, o_bus_wdata, o_bus_strb, o_wb_dst_rob, o_wb_fid, o_wb_data} !== '0) begin
      errors++; $display("FAIL reset_data got addr=%h wdata=%h strb=%h rob=%h fid=%h data=%h exp all 0",
                         o_bus_addr, o_bus_wdata, o_bus_strb, o_wb_dst_rob, o_wb_fid, o_wb_data);
    end
    resetn = 1;
  endtask

  task automatic test_word_load();
    int ns, nr, nw, wa; logic [3:0] wr; logic [7:0] wf; logic [31:0] wd, ba, bw;
    logic we; logic [3:0] bs; logic stb;
    run_txn(4'h5, 8'h3C, 0, 0, 1, 1, 32'h1F00_0004, $urandom, 32'hDEADBEEF, 2, -1,
            ns, nr, nw, wa, wr, wf, wd, we, ba, bw, bs, stb);
    checks++; if (ns !== 4) begin errors++; $display("FAIL word_load stall_cycles got %0d exp 4", ns); end
    checks++; if (nw !== 1 || wa !== 4) begin errors++; $display("FAIL word_load wb got count=%0d at=%0d exp 1 at 4", nw, wa); end
    checks++; if ({wr, wf, wd} !== {4'h5, 8'h3C, 32'hDEADBEEF}) begin
      errors++; $display("FAIL word_load wb_fields got %h/%h/%h exp 5/3c/deadbeef", wr, wf, wd); end
    checks++; if ({we, ba, bs} !== {1'b0, 32'h1F00_0004, 4'hF}) begin
      errors++; $display("FAIL word_load bus got we=%b addr=%h strb=%h exp 0/1f000004/f", we, ba, bs); end
  endtask

  task automatic test_byte_store();
    int ns, nr, nw, wa; logic [3:0] wr; logic [7:0] wf; logic [31:0] wd, ba, bw;
    logic we; logic [3:0] bs; logic stb;
    run_txn(4'hA, 8'h11, 1, 1, 0, 1, 32'h1F00_0002, 32'h0000_00A5, $urandom, 3, -1,
            ns, nr, nw, wa, wr, wf, wd, we, ba, bw, bs, stb);
    checks++; if ({we, ba, bw, bs} !== {1'b1, 32'h1F00_0002, 32'hA5A5A5A5, 4'b0100}) begin
      errors++; $display("FAIL byte_store bus got we=%b addr=%h wdata=%h strb=%b exp 1/1f000002/a5a5a5a5/0100",
                         we, ba, bw, bs); end
    checks++; if (stb !== 1 || nr !== 4) begin errors++; $display("FAIL byte_store req got stable=%b cycles=%0d exp 1/4", stb, nr); end
    checks++; if (nw !== 1 || wd !== 32'h0) begin errors++; $display("FAIL byte_store wb got count=%0d data=%h exp 1/0", nw, wd); end
  endtask

  task automatic test_byte_load_fast();
    int ns, nr, nw, wa; logic [3:0] wr; logic [7:0] wf; logic [31:0] wd, ba, bw;
    logic we; logic [3:0] bs; logic stb;
    run_txn(4'h3, 8'h77, 1, 0, 1, 1, 32'h1F00_0003, 0, 32'h12345678, 0, -1,
            ns, nr, nw, wa, wr, wf, wd, we, ba, bw, bs, stb);
    checks++; if (wd !== 32'h12 || nw !== 1) begin errors++; $display("FAIL byte_load data got %h count=%0d exp 00000012/1", wd, nw); end
    checks++; if (wa !== 2 || ns !== 2) begin errors++; $display("FAIL byte_load latency got wb_at=%0d stall=%0d exp 2/2", wa, ns); end
    checks++; if (bs !== 4'b1000) begin errors++; $display("FAIL byte_load strb got %b exp 1000", bs); end
  endtask

  task automatic test_bco();
    int ns, nr, nw, wa; logic [3:0] wr; logic [7:0] wf; logic [31:0] wd, ba, bw;
    logic we; logic [3:0] bs; logic stb;
    // flush in REQ before ack: drains for the full 6 request cycles
    run_txn(4'h1, 8'h01, 0, 0, 1, 1, 32'h1F00_0100, 0, 32'h55, 5, 2,
            ns, nr, nw, wa, wr, wf, wd, we, ba, bw, bs, stb);
    checks++; if (nr !== 6 || nw !== 0 || ns !== 7 || stb !== 1) begin
      errors++; $display("FAIL bco_drain got req=%0d wb=%0d stall=%0d stable=%b exp 6/0/7/1", nr, nw, ns, stb); end
    // flush in the ack cycle
    run_txn(4'h2, 8'h02, 0, 0, 1, 1, 32'h1F00_0104, 0, 32'h66, 1, 2,
            ns, nr, nw, wa, wr, wf, wd, we, ba, bw, bs, stb);
    checks++; if (nr !== 2 || nw !== 0) begin errors++; $display("FAIL bco_ack got req=%0d wb=%0d exp 2/0", nr, nw); end
    // flush in the RESP cycle
    run_txn(4'h3, 8'h03, 0, 1, 0, 1, 32'h1F00_0108, 1, 32'h77, 1, 3,
            ns, nr, nw, wa, wr, wf, wd, we, ba, bw, bs, stb);
    checks++; if (nw !== 0 || ns !== 3) begin errors++; $display("FAIL bco_resp got wb=%0d stall=%0d exp 0/3", nw, ns); end
    // flush together with the candidate
    run_txn(4'h4, 8'h04, 0, 0, 1, 1, 32'h1F00_010C, 0, 32'h88, 1, 0,
            ns, nr, nw, wa, wr, wf, wd, we, ba, bw, bs, stb);
    checks++; if (ns !== 0 || nr !== 0 || nw !== 0) begin
      errors++; $display("FAIL bco_candidate got stall=%0d req=%0d wb=%0d exp 0/0/0", ns, nr, nw); end
  endtask

  task automatic test_drain_reaccept();
    logic wb_seen;
    wb_seen = 0;
    @(negedge clk);
    i_valid = 1; i_p_uncached = 1; i_s_load = 1; i_s_store = 0; i_s_byte = 0;
    i_p_addr = 32'h1F00_0010; i_dst_rob = 4'h6; i_fid = 8'h66;
    @(negedge clk); bco_valid = 1; #1;
    checks++; if (o_bus_req !== 1) begin errors++; $display("FAIL drain_req1 got %b exp 1", o_bus_req); end
    // new uncached store arrives after the flush while the old read drains
    @(negedge clk); bco_valid = 0; i_s_load = 0; i_s_store = 1; i_p_addr = 32'h1F00_0020; #1;
    wb_seen = wb_seen | o_wb_valid;
    checks++; if ({o_bus_req, o_stall, o_bus_addr} !== {2'b11, 32'h1F00_0010}) begin
      errors++; $display("FAIL drain_hold got req=%b stall=%b addr=%h exp 1/1/1f000010", o_bus_req, o_stall, o_bus_addr); end
    @(negedge clk); i_bus_ack = 1; #1;
    wb_seen = wb_seen | o_wb_valid;
    @(negedge clk); i_bus_ack = 0; #1;
    wb_seen = wb_seen | o_wb_valid;
    checks++; if ({o_bus_req, o_stall, wb_seen} !== 3'b010) begin
      errors++; $display("FAIL drain_reaccept got req=%b stall=%b wb=%b exp 0/1/0", o_bus_req, o_stall, wb_seen); end
    @(negedge clk); i_bus_ack = 1; #1;
    checks++; if ({o_bus_req, o_bus_we, o_bus_addr} !== {2'b11, 32'h1F00_0020}) begin
      errors++; $display("FAIL drain_second got req=%b we=%b addr=%h exp 1/1/1f000020", o_bus_req, o_bus_we, o_bus_addr); end
    @(negedge clk); i_bus_ack = 0; #1;
    checks++; if ({o_wb_valid, o_wb_data} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL drain_second_wb got valid=%b data=%h exp 1/0", o_wb_valid, o_wb_data); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    i_valid = 1; i_p_uncached = 1; i_s_load = 1; i_p_addr = 32'h1F00_0040;
    i_dst_rob = 4'hF; i_fid = 8'hF0; i_src1_value = 32'hFFFF_FFFF;
    @(negedge clk); i_valid = 0; resetn = 0; #1;
    checks++; if (o_bus_req !== 1) begin errors++; $display("FAIL rst_mid_before got %b exp 1", o_bus_req); end
    @(negedge clk); #1;
    checks++; if ({o_bus_req, o_wb_valid, o_stall, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_strb,
                   o_wb_dst_rob, o_wb_fid, o_wb_data} !== '0) begin
      errors++; $display("FAIL rst_mid_after got req=%b addr=%h strb=%h rob=%h fid=%h exp all 0",
                         o_bus_req, o_bus_addr, o_bus_strb, o_wb_dst_rob, o_wb_fid); end
    resetn = 1;
    idle_inputs();
  endtask

  task automatic test_cached();
    int ns, nr, nw, wa; logic [3:0] wr; logic [7:0] wf; logic [31:0] wd, ba, bw;
    logic we; logic [3:0] bs; logic stb;
    run_txn(4'h7, 8'h70, 0, 0, 1, 0, 32'h0000_1000, 0, 32'h99, 1, -1,
            ns, nr, nw, wa, wr, wf, wd, we, ba, bw, bs, stb);
    checks++; if (ns !== 0 || nr !== 0 || nw !== 0) begin
      errors++; $display("FAIL cached got stall=%0d req=%0d wb=%0d exp 0/0/0", ns, nr, nw); end
  endtask

  task automatic test_random();
    int ns, nr, nw, wa; logic [3:0] wr; logic [7:0] wf; logic [31:0] wd, ba, bw;
    logic we; logic [3:0] bs; logic stb;
    for (int n = 0; n < 40; n++) begin
      logic [3:0] rob; logic [7:0] fid; logic bt, st, ld, unc; logic [31:0] addr, src, rd;
      int ad, bco_at; bit acc, e_wb;
      rob = 4'($urandom); fid = 8'($urandom); bt = 1'($urandom); st = 1'($urandom);
      ld = 1'($urandom); unc = ($urandom_range(0, 7) != 0); addr = $urandom;
      src = $urandom; rd = $urandom; ad = $urandom_range(0, 4);
      bco_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, ad + 4)) : -1;
      run_txn(rob, fid, bt, st, ld, unc, addr, src, rd, ad, bco_at,
              ns, nr, nw, wa, wr, wf, wd, we, ba, bw, bs, stb);
      acc  = unc && (ld || st) && bco_at != 0;
      e_wb = acc && !(bco_at >= 1 && bco_at <= ad + 2);
      checks++;
      if (ns !== (acc ? ad + 2 : 0) || nr !== (acc ? ad + 1 : 0) || nw !== (e_wb ? 1 : 0)) begin
        errors++; $display("FAIL rnd%0d counts got stall=%0d req=%0d wb=%0d exp %0d/%0d/%0d", n, ns, nr, nw,
                           acc ? ad + 2 : 0, acc ? ad + 1 : 0, e_wb ? 1 : 0);
      end
      if (acc) begin
        checks++;
        if ({we, ba, bw, bs, stb} !== {st, m_addr(addr, bt), m_wdata(src, bt), m_strb(addr, bt), 1'b1}) begin
          errors++; $display("FAIL rnd%0d bus got we=%b addr=%h wdata=%h strb=%h stable=%b exp %b/%h/%h/%h/1", n,
                             we, ba, bw, bs, stb, st, m_addr(addr, bt), m_wdata(src, bt), m_strb(addr, bt));
        end
      end
      if (e_wb) begin
        checks++;
        if ({wr, wf, wd} !== {rob, fid, m_load(rd, addr, bt, st)} || wa !== ad + 2) begin
          errors++; $display("FAIL rnd%0d wb got %h/%h/%h at %0d exp %h/%h/%h at %0d", n, wr, wf, wd, wa,
                             rob, fid, m_load(rd, addr, bt, st), ad + 2);
        end
      end
    end
  endtask

  initial begin
    idle_inputs();
    resetn = 0;
    test_reset();
    test_word_load();
    test_byte_store();
    test_byte_load_fast();
    test_bco();
    test_drain_reaccept();
    test_reset_mid();
    test_cached();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
